ddmm_seq: RTL and testbench
===========================

DDMM_SEQ -- requirements
Module: ddmm_seq

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD day-of-year input digits.
REQ-002 Parameter LAST_MONTH, default 12: highest month resolved, legal range 1..12.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed in REQ-004 and REQ-005.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 doy_bcd  in  4*DIGITS  day-of-year as BCD digits, most-significant digit first.
REQ-007 leap  in  1  leap-year select; Feb = 29 days when set.
REQ-008 in_valid  in  1  doy_bcd and leap are valid.
REQ-009 in_ready  out  1  block can accept a request.
REQ-010 mm  out  4  month, binary, 1..LAST_MONTH.
REQ-011 dd  out  5  day of month, binary, 1..31.
REQ-012 err  out  1  request invalid; mm and dd forced to 0.
REQ-013 out_valid  out  1  mm, dd and err hold a result.
REQ-014 out_ready  in  1  consumer accepts the result.

Function
REQ-015 FSM states: IDLE, CONV, WALK, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept on the edge where in_valid && in_ready; capture doy_bcd and leap; go to CONV. Leap changes after accept SHALL be ignored.
REQ-017 CONV (1 cycle) SHALL convert the BCD to binary rem, of width clog2(10**DIGITS), and set month index = 1.
REQ-018 In CONV, any digit >9, value 0, or value > (sum of month lengths 1..LAST_MONTH incl. leap) SHALL go to DONE with err=1, mm=0, dd=0.
REQ-019 WALK, per cycle: if rem <= len(month), then mm=month, dd=rem, go to DONE; otherwise rem -= len(month) and month++.
REQ-020 Month lengths SHALL be 31,28+leap,31,30,31,30,31,31,30,31,30,31.
REQ-021 Latency for a result in month m: out_valid SHALL rise m+2 cycles after the accept edge. Errors: 2 cycles.
REQ-022 DONE: out_valid=1 with outputs stable until the out_valid && out_ready edge, then IDLE.
REQ-023 Back-to-back: next accept no earlier than the cycle after the DONE handshake; no request SHALL be dropped or overlapped.
REQ-024 Outputs SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-025 On reset_n low, in any state: IDLE, in_ready=1 after release, out_valid=0, mm=0, dd=0, err=0, internal rem/month cleared.
REQ-026 Reset mid-CONV/WALK/DONE SHALL discard the request with no out_valid pulse.

Configuration
REQ-027 Macro DDMM_SEQ_BCD_OUT_EN: when defined, ports mm_bcd[7:0] and dd_bcd[7:0] are added, registered with mm/dd, and zero when err=1 or in reset.
REQ-028 Without DDMM_SEQ_BCD_OUT_EN those ports SHALL be absent, and binary behaviour SHALL be identical.

Structure
REQ-029 Package ddmm_pkg SHALL hold the state enum, the month-length constant table, and the month/day width constants.
REQ-030 Sub-module bcd_to_bin, parametrised by DIGITS, SHALL do the BCD-to-binary conversion and digit-validity flag used in CONV.

Verification
REQ-031 doy=001, leap=0 -> mm=1, dd=1, err=0; out_valid rises 3 cycles after accept.
REQ-032 doy=060 -> leap=0: mm=3, dd=1; leap=1: mm=2, dd=29; leap toggled after accept has no effect.
REQ-033 doy=366, leap=1 -> mm=12, dd=31 at latency 14. doy=366, leap=0 -> err=1, mm=0, dd=0 at latency 2.
REQ-034 doy=000, and doy=0x1A5 (digit A) -> err=1. With LAST_MONTH=4: doy=121, leap=0 -> mm=5 is impossible, so err=1; doy=120, leap=0 -> mm=4, dd=30.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; then 1-cycle handshake -> IDLE.
REQ-036 reset_n pulsed low during WALK of doy=300 -> no out_valid; the following request doy=032 -> mm=2, dd=1.

Source files
------------

// File: rtl/ddmm_pkg.sv
// Shared types and calendar constants for the day-of-year to month/day converter.
package ddmm_pkg;

    localparam int MW = 4;
    localparam int DW = 5;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WALK,
        DONE
    } state_t;

    // Indexed by month number; entries 0 and 13..15 are never reached.
    localparam logic [DW-1:0] MONTH_DAYS [16] = '{
        5'd0,  5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd0,  5'd0,  5'd0
    };

    function automatic logic [DW-1:0] month_len(
        input logic [MW-1:0] m,
        input logic          leap
    );
        logic [DW-1:0] len;
        len = MONTH_DAYS[m];
        if (m == MW'(2) && leap)
            len = len + DW'(1);
        return len;
    endfunction

    function automatic int unsigned year_days(
        input int   last,
        input logic leap
    );
        int unsigned s;
        s = 0;
        for (int i = 1; i <= 12; i++)
            if (i <= last)
                s += 32'(MONTH_DAYS[i[3:0]]);
        if (leap && last >= 2)
            s += 1;
        return s;
    endfunction

    function automatic logic [7:0] to_bcd8(input logic [DW-1:0] v);
        return {4'(v / DW'(10)), 4'(v % DW'(10))};
    endfunction

endpackage

// File: rtl/ddmm_seq_if.sv
// Request/result bundle for ddmm_seq.
// DDMM_SEQ_BCD_OUT_EN adds BCD copies of the month and day.
interface ddmm_seq_if #(
    parameter int DIGITS = 3
);
    import ddmm_pkg::*;

    logic [4*DIGITS-1:0] doy_bcd;
    logic                leap;
    logic                in_valid;
    logic                in_ready;
    logic [MW-1:0]       mm;
    logic [DW-1:0]       dd;
    logic                err;
    logic                out_valid;
    logic                out_ready;

`ifdef DDMM_SEQ_BCD_OUT_EN
    logic [7:0]          mm_bcd;
    logic [7:0]          dd_bcd;

    modport master (
        output doy_bcd, leap, in_valid, out_ready,
        input  in_ready, mm, dd, err, out_valid, mm_bcd, dd_bcd
    );
    modport slave (
        input  doy_bcd, leap, in_valid, out_ready,
        output in_ready, mm, dd, err, out_valid, mm_bcd, dd_bcd
    );
`else
    modport master (
        output doy_bcd, leap, in_valid, out_ready,
        input  in_ready, mm, dd, err, out_valid
    );
    modport slave (
        input  doy_bcd, leap, in_valid, out_ready,
        output in_ready, mm, dd, err, out_valid
    );
`endif

endinterface

// File: rtl/bcd_to_bin.sv
// BCD digit string to binary, with a flag that every digit is 0..9.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BW     = $clog2(10**DIGITS)
) (
    input  logic [4*DIGITS-1:0] bcd,
    output logic [BW-1:0]       bin,
    output logic                ok
);

    always_comb begin
        bin = '0;
        ok  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] > 4'd9)
                ok = 1'b0;
            bin = (bin * BW'(10)) + BW'(bcd[4*i +: 4]);
        end
    end

endmodule

// File: rtl/ddmm_seq.sv
// Sequential day-of-year to month/day converter: one month examined per cycle.
// DDMM_SEQ_BCD_OUT_EN adds registered BCD month/day outputs.
module ddmm_seq
    import ddmm_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter int LAST_MONTH = 12
) (
    input logic       clock,
    input logic       reset_n,
    ddmm_seq_if.slave bus
);

    localparam int          RW     = $clog2(10**DIGITS);
    localparam int unsigned DAYS_N = year_days(LAST_MONTH, 1'b0);
    localparam int unsigned DAYS_L = year_days(LAST_MONTH, 1'b1);

    state_t              state, state_n;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                leap_q, leap_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [MW-1:0]       mon_q, mon_d;
    logic [MW-1:0]       mm_q, mm_d;
    logic [DW-1:0]       dd_q, dd_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;
    logic [RW-1:0]       bin;
    logic                ok;
    logic [DW-1:0]       len;
    int unsigned         limit;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BW     (RW)
    ) u_b2b (
        .bcd (bcd_q),
        .bin (bin),
        .ok  (ok)
    );

    assign len   = month_len(mon_q, leap_q);
    assign limit = leap_q ? DAYS_L : DAYS_N;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q  <= '0;
            leap_q <= 1'b0;
            rem_q  <= '0;
            mon_q  <= '0;
            mm_q   <= '0;
            dd_q   <= '0;
            err_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            leap_q <= leap_d;
            rem_q  <= rem_d;
            mon_q  <= mon_d;
            mm_q   <= mm_d;
            dd_q   <= dd_d;
            err_q  <= err_d;
            ov_q   <= ov_d;
        end
    end

    always_comb begin
        state_n = state;
        bcd_d   = bcd_q;
        leap_d  = leap_q;
        rem_d   = rem_q;
        mon_d   = mon_q;
        mm_d    = mm_q;
        dd_d    = dd_q;
        err_d   = err_q;
        ov_d    = ov_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    bcd_d   = bus.doy_bcd;
                    leap_d  = bus.leap;
                    mm_d    = '0;
                    dd_d    = '0;
                    err_d   = 1'b0;
                    state_n = CONV;
                end
            end
            CONV: begin
                rem_d = bin;
                mon_d = MW'(1);
                if (!ok || bin == '0 || 32'(bin) > limit) begin
                    err_d   = 1'b1;
                    mm_d    = '0;
                    dd_d    = '0;
                    state_n = DONE;
                end else begin
                    state_n = WALK;
                end
            end
            WALK: begin
                if (32'(rem_q) <= 32'(len)) begin
                    mm_d    = mon_q;
                    dd_d    = DW'(rem_q);
                    state_n = DONE;
                end else begin
                    rem_d = rem_q - RW'(len);
                    mon_d = mon_q + MW'(1);
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE
                ov_d = 1'b1;
                if (ov_q && bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.mm        = mm_q;
    assign bus.dd        = dd_q;
    assign bus.err       = err_q;
    assign bus.out_valid = ov_q;

`ifdef DDMM_SEQ_BCD_OUT_EN
    logic [7:0] mm_bcd_q, dd_bcd_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mm_bcd_q <= '0;
            dd_bcd_q <= '0;
        end else begin
            mm_bcd_q <= to_bcd8(DW'(mm_d));
            dd_bcd_q <= to_bcd8(dd_d);
        end
    end

    assign bus.mm_bcd = mm_bcd_q;
    assign bus.dd_bcd = dd_bcd_q;
`endif

endmodule

// File: tb/tb_ddmm_seq.sv
// Randomized and directed checks of ddmm_seq against a cumulative-days model.
// Unit a: LAST_MONTH=12; unit b: LAST_MONTH=4.
module tb_ddmm_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ddmm_seq_if ia ();
    ddmm_seq_if ib ();

    ddmm_seq #(
        .DIGITS     (3),
        .LAST_MONTH (12)
    ) dut_a (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (ia)
    );

    ddmm_seq #(
        .DIGITS     (3),
        .LAST_MONTH (4)
    ) dut_b (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (ib)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Month found from cumulative day counts rather than stepping.
    task automatic model(
        input  logic [11:0] d,
        input  logic        lp,
        input  int          last,
        output int          mm,
        output int          dd,
        output int          err,
        output int          lat
    );
        int len [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int cum [13];
        int v;
        bit bad;
        bad = 1'b0;
        v   = 0;
        for (int i = 2; i >= 0; i--) begin
            int dg;
            dg = int'(d[4*i +: 4]);
            if (dg > 9) bad = 1'b1;
            v = v * 10 + dg;
        end
        if (lp) len[2] = 29;
        cum[0] = 0;
        for (int m = 1; m <= 12; m++) cum[m] = cum[m-1] + len[m];
        mm  = 0;
        dd  = 0;
        err = 0;
        lat = 2;
        if (bad || v == 0 || v > cum[last]) begin
            err = 1;
            return;
        end
        for (int m = 1; m <= last; m++)
            if (mm == 0 && v <= cum[m]) begin
                mm = m;
                dd = v - cum[m-1];
            end
        lat = mm + 2;
    endtask

    function automatic int ov(input bit b);
        return b ? int'(ib.out_valid) : int'(ia.out_valid);
    endfunction
    function automatic int ir(input bit b);
        return b ? int'(ib.in_ready) : int'(ia.in_ready);
    endfunction
    function automatic int gmm(input bit b);
        return b ? int'(ib.mm) : int'(ia.mm);
    endfunction
    function automatic int gdd(input bit b);
        return b ? int'(ib.dd) : int'(ia.dd);
    endfunction
    function automatic int ger(input bit b);
        return b ? int'(ib.err) : int'(ia.err);
    endfunction
`ifdef DDMM_SEQ_BCD_OUT_EN
    function automatic int gmb(input bit b);
        return b ? int'(ib.mm_bcd) : int'(ia.mm_bcd);
    endfunction
    function automatic int gdb(input bit b);
        return b ? int'(ib.dd_bcd) : int'(ia.dd_bcd);
    endfunction
`endif

    task automatic drv(
        input bit          b,
        input logic [11:0] d,
        input logic        l,
        input logic        v,
        input logic        r
    );
        if (b) begin
            ib.doy_bcd   = d;
            ib.leap      = l;
            ib.in_valid  = v;
            ib.out_ready = r;
        end else begin
            ia.doy_bcd   = d;
            ia.leap      = l;
            ia.in_valid  = v;
            ia.out_ready = r;
        end
    endtask

    task automatic run(
        input bit          b,
        input logic [11:0] d,
        input logic        lp,
        input int          stall,
        input bit          tog
    );
        int emm, edd, eerr, elat, lat;
        model(d, lp, b ? 4 : 12, emm, edd, eerr, elat);
        @(negedge clk);
        chk("idle_ready", ir(b), 1);
        drv(b, d, lp, 1'b1, stall == 0);
        @(posedge clk);
        #1;
        if (tog)
            drv(b, 12'($urandom), ~lp, 1'b0, stall == 0);
        else
            drv(b, d, lp, 1'b0, stall == 0);
        lat = 0;
        while (ov(b) == 0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("mm", gmm(b), emm);
        chk("dd", gdd(b), edd);
        chk("err", ger(b), eerr);
`ifdef DDMM_SEQ_BCD_OUT_EN
        chk("mm_bcd", gmb(b), (emm / 10) * 16 + emm % 10);
        chk("dd_bcd", gdb(b), (edd / 10) * 16 + edd % 10);
`endif
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                drv(b, 12'($urandom), 1'($urandom), 1'b1, 1'b0);
                @(posedge clk);
                #1;
                chk("hold_valid", ov(b), 1);
                chk("hold_ready", ir(b), 0);
                chk("hold_mm", gmm(b), emm);
                chk("hold_dd", gdd(b), edd);
                chk("hold_err", ger(b), eerr);
            end
            @(negedge clk);
            drv(b, d, lp, 1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("hs_valid", ov(b), 0);
        chk("hs_ready", ir(b), 1);
        @(negedge clk);
        drv(b, d, lp, 1'b0, 1'b0);
    endtask

    function automatic logic [11:0] to_bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int seen;
        drv(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 12'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", ov(1'b0), 0);
        chk("rst_mm_a", gmm(1'b0), 0);
        chk("rst_dd_a", gdd(1'b0), 0);
        chk("rst_err_a", ger(1'b0), 0);
        chk("rst_valid_b", ov(1'b1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_a", ir(1'b0), 1);
        chk("rst_ready_b", ir(1'b1), 1);

        run(1'b0, 12'h001, 1'b0, 0, 1'b0);
        run(1'b0, 12'h060, 1'b0, 0, 1'b1);
        run(1'b0, 12'h060, 1'b1, 0, 1'b1);
        run(1'b0, 12'h366, 1'b1, 0, 1'b0);
        run(1'b0, 12'h366, 1'b0, 0, 1'b0);
        run(1'b0, 12'h365, 1'b0, 0, 1'b0);
        run(1'b0, 12'h000, 1'b0, 0, 1'b0);
        run(1'b0, 12'h1A5, 1'b0, 0, 1'b0);
        run(1'b1, 12'h121, 1'b0, 0, 1'b0);
        run(1'b1, 12'h120, 1'b0, 0, 1'b0);
        run(1'b1, 12'h121, 1'b1, 0, 1'b0);
        run(1'b0, 12'h150, 1'b0, 5, 1'b0);

        repeat (40) begin
            logic [11:0] d;
            bit b;
            b = ($urandom_range(0, 3) == 0);
            d = to_bcd3(b ? int'($urandom_range(0, 140)) : int'($urandom_range(0, 399)));
            if ($urandom_range(0, 9) == 0)
                d[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            run(b, d, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        @(negedge clk);
        drv(1'b0, 12'h300, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drv(1'b0, 12'h300, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ov(1'b0), 0);
        chk("midrst_mm", gmm(1'b0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", ir(1'b0), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ia.out_valid) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        run(1'b0, 12'h032, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
